peripheral_mpi_ahb_slave: RTL and testbench
===========================================

Name: peripheral_mpi_ahb_slave

Overview:
AHB-Lite slave front end for the MPI message buffer. It converts pipelined AHB-Lite address and data phases into the generic single-outstanding bus handshake (bus_en/bus_we/bus_ack/bus_err) that the MPI buffer consumes. It inserts wait states until the buffer acknowledges and generates the two-cycle AHB ERROR response. It sits directly upstream of the MPI buffer, between the tile interconnect and the buffer's bus side.

Parameters:
PLEN, 32, AHB address width.
XLEN, 32, AHB data width; must be 32 (buffer is word-only).
TIMEOUT, 255, maximum data-phase cycles to wait for bus_ack/bus_err before forcing an ERROR response; must be >= 1.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
biu_hsel_i  in  1  slave select
biu_haddr_i  in  PLEN  address (address phase)
biu_hwdata_i  in  XLEN  write data (data phase)
biu_hwrite_i  in  1  1=write
biu_hsize_i  in  3  transfer size
biu_hburst_i  in  3  burst type (ignored; every beat is handled independently)
biu_hprot_i  in  4  protection (ignored)
biu_htrans_i  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
biu_hmastlock_i  in  1  locked transfer (ignored)
biu_hready_i  in  1  bus-wide HREADY (previous transfer complete)
biu_hrdata_o  out  XLEN  read data
biu_hready_o  out  1  slave ready
biu_hresp_o  out  1  0=OKAY, 1=ERROR
bus_addr  out  32  word address to buffer
bus_we  out  1  write enable to buffer
bus_en  out  1  access request to buffer
bus_data_in  out  32  write data to buffer
bus_data_out  in  32  read data from buffer
bus_ack  in  1  buffer completes access
bus_err  in  1  buffer rejects access

Behaviour:
- Clock/reset: single clock clk. Reset rst is asynchronous and active-high. All state is cleared on rst assertion without waiting for a clock edge.
- Reset values: state=IDLE, biu_hready_o=1, biu_hresp_o=0, biu_hrdata_o=0, bus_en=0, bus_we=0, bus_addr=0, timeout counter=0.
- Address phase accept: a transfer is accepted when biu_hsel_i & biu_hready_i & biu_htrans_i[1] are all 1 on a rising edge.
  - On accept, latch haddr, hwrite and hsize.
  - IDLE/BUSY transfers, or transfers while unselected, get a zero-wait OKAY response.
- Illegal transfer: hsize != 3'b010 or haddr[1:0] != 0.
  - The buffer is not accessed; state goes to ERR1.
- States:
  - IDLE: hready_o=1, hresp_o=0. A legal accept goes to ACCESS; an illegal accept goes to ERR1.
  - ACCESS: bus_en=1, bus_addr=latched addr, bus_we=latched write, bus_data_in=biu_hwdata_i (combinational, valid in data phase).
    - hready_o=0 until termination.
    - If bus_ack=1: same cycle hready_o=1, hresp_o=0, biu_hrdata_o=bus_data_out. The next state is ACCESS/ERR1 if a new accept occurs in that cycle (back-to-back, no bubble), else IDLE.
    - If bus_err=1 (takes priority over a simultaneous bus_ack): drop bus_en next cycle and go to ERR1.
    - If the counter reaches TIMEOUT without ack/err: go to ERR1 and drop bus_en.
  - ERR1: hready_o=0, hresp_o=1, bus_en=0. Go to ERR2.
  - ERR2: hready_o=1, hresp_o=1. An accept in this cycle is honoured as in IDLE; otherwise go to IDLE.
- Timeout counter: clog2(TIMEOUT+1) bits. Cleared on entry to ACCESS, incremented each ACCESS cycle without ack/err, saturating.
- Read data: biu_hrdata_o is registered-hold. It is updated only on the bus_ack cycle of a read and holds its value otherwise.
- Buffer handshake: bus_en, bus_addr and bus_we stay stable for the whole ACCESS state. There is at most one outstanding access.
- Reset mid-access: bus_en drops immediately (asynchronous) and the pending transfer is abandoned with no response.

Test Plan:
- Single write: NONSEQ write to 0x0000_0010 with hwdata=0xDEADBEEF; buffer acks after 2 cycles -> bus_en high 3 cycles with bus_we=1 and bus_addr=0x10; hready_o low 2 cycles, then high with hresp_o=0.
- Back-to-back reads: NONSEQ then SEQ reads to 0x0 and 0x4; buffer acks immediately returning 0x11 then 0x22 -> no idle cycle between the two bus_en accesses; hrdata=0x11 then 0x22 on the hready_o=1 cycles.
- Illegal size: hsize=3'b000 to 0x4 -> bus_en never asserted; hresp_o=1 for 2 cycles with hready_o=0 then 1.
- Buffer error: bus_err and bus_ack both asserted in the first data cycle -> ERROR response (ERR1, ERR2); bus_en deasserted the next cycle.
- Timeout: with TIMEOUT=4 and the buffer never acking -> bus_en high exactly 4 cycles, then a two-cycle ERROR response, then IDLE.
- Reset mid-access: assert rst during ACCESS between clock edges -> bus_en=0 and hready_o=1 immediately; after release, a NONSEQ read to 0x8 completes normally.

Source files
------------

// File: rtl/peripheral_mpi_ahb_slave.sv
// AHB-Lite slave front end for the MPI message buffer: turns pipelined AHB
// transfers into a single-outstanding en/we/ack/err handshake with wait states.
module peripheral_mpi_ahb_slave #(
  parameter int PLEN    = 32,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            biu_hsel_i,
  input  logic [PLEN-1:0] biu_haddr_i,
  input  logic [XLEN-1:0] biu_hwdata_i,
  input  logic            biu_hwrite_i,
  input  logic [2:0]      biu_hsize_i,
  input  logic [2:0]      biu_hburst_i,
  input  logic [3:0]      biu_hprot_i,
  input  logic [1:0]      biu_htrans_i,
  input  logic            biu_hmastlock_i,
  input  logic            biu_hready_i,
  output logic [XLEN-1:0] biu_hrdata_o,
  output logic            biu_hready_o,
  output logic            biu_hresp_o,
  output logic [31:0]     bus_addr,
  output logic            bus_we,
  output logic            bus_en,
  output logic [31:0]     bus_data_in,
  input  logic [31:0]     bus_data_out,
  input  logic            bus_ack,
  input  logic            bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, ERR1, ERR2} state_e;

  state_e          state_q, state_d;
  logic [PLEN-1:0] addr_q, addr_d;
  logic            we_q, we_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            hready;
  logic            take_ok;
  logic            rd_pass;

  wire accept = biu_hsel_i & biu_hready_i & biu_htrans_i[1];
  wire legal  = (biu_hsize_i == 3'b010) && (biu_haddr_i[1:0] == 2'b00);

  logic unused_ok;
  assign unused_ok = ^{biu_hburst_i, biu_hprot_i, biu_hmastlock_i, biu_htrans_i[0]};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    hready  = 1'b1;
    take_ok = 1'b0;
    rd_pass = 1'b0;
    case (state_q)
      IDLE: take_ok = 1'b1;
      ACCESS: begin
        hready = 1'b0;
        if (bus_err) begin
          state_d = ERR1;
        end else if (bus_ack) begin
          hready  = 1'b1;
          take_ok = 1'b1;
          state_d = IDLE;
          if (!we_q) begin
            rd_pass = 1'b1;
            rdata_d = XLEN'(bus_data_out);
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = ERR1;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ERR1: begin
        hready  = 1'b0;
        state_d = ERR2;
      end
      ERR2: begin
        take_ok = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new address phase may overlap the completing data phase (no bubble).
    if (take_ok && accept) begin
      addr_d = biu_haddr_i;
      we_d   = biu_hwrite_i;
      if (legal) begin
        state_d = ACCESS;
        cnt_d   = '0;
      end else begin
        state_d = ERR1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign biu_hready_o = hready;
  assign biu_hresp_o  = (state_q == ERR1) || (state_q == ERR2);
  assign biu_hrdata_o = rd_pass ? rdata_d : rdata_q;
  assign bus_en       = (state_q == ACCESS);
  assign bus_we       = bus_en & we_q;
  assign bus_addr     = 32'(addr_q);
  assign bus_data_in  = 32'(biu_hwdata_i);

endmodule

// File: tb/tb_peripheral_mpi_ahb_slave.sv
// Bench for peripheral_mpi_ahb_slave: behavioural buffer responder plus a
// response scoreboard checked whenever a data phase completes.
module tb_peripheral_mpi_ahb_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [1:0]  htrans = 2'b00;
  logic        hready_i;
  logic [31:0] hrdata;
  logic        hready_o;
  logic        hresp;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic        bus_en;
  logic [31:0] bus_data_in;
  logic [31:0] bus_data_out;
  logic        bus_ack;
  logic        bus_err;

  int          checks = 0;
  int          errors = 0;

  // Buffer model
  int          ack_lat = 0;
  logic        err_mode = 1'b0;
  int          en_cnt = 0;
  logic [31:0] rmem [16];
  logic [31:0] last_wdata = '0;
  logic [31:0] last_waddr = '0;

  typedef struct {
    logic        resp;
    logic        chk;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  logic dphase;

  always #5 clk = ~clk;

  assign hready_i     = hready_o;
  assign bus_ack      = bus_en && (en_cnt == ack_lat);
  assign bus_err      = bus_en && err_mode && (en_cnt == 0);
  assign bus_data_out = rmem[bus_addr[5:2]];

  always @(posedge clk) begin
    if (bus_en && !(bus_ack || bus_err)) en_cnt <= en_cnt + 1;
    else en_cnt <= 0;
    if (bus_en && bus_ack && !bus_err && bus_we) begin
      last_wdata <= bus_data_in;
      last_waddr <= bus_addr;
    end
  end

  peripheral_mpi_ahb_slave #(.PLEN(32), .XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .biu_hsel_i(hsel), .biu_haddr_i(haddr), .biu_hwdata_i(hwdata),
    .biu_hwrite_i(hwrite), .biu_hsize_i(hsize), .biu_hburst_i(3'b000),
    .biu_hprot_i(4'b0011), .biu_htrans_i(htrans), .biu_hmastlock_i(1'b0),
    .biu_hready_i(hready_i), .biu_hrdata_o(hrdata), .biu_hready_o(hready_o),
    .biu_hresp_o(hresp), .bus_addr(bus_addr), .bus_we(bus_we), .bus_en(bus_en),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
    .bus_ack(bus_ack), .bus_err(bus_err)
  );

  // Track open data phases and score each one as it completes.
  always @(posedge clk or posedge rst) begin
    if (rst) dphase <= 1'b0;
    else if (hready_o) dphase <= hsel & htrans[1];
  end

  always @(negedge clk) begin
    if (!rst && dphase && hready_o) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: response with empty scoreboard, hresp=%0b", hresp);
      end else begin
        e = sb.pop_front();
        if (hresp !== e.resp || (e.chk && hrdata !== e.data)) begin
          errors++;
          $display("FAIL sb_resp: got hresp=%0b hrdata=%h, want hresp=%0b hrdata=%h",
                   hresp, hrdata, e.resp, e.data);
        end
      end
    end
  end

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz,
                            input logic [1:0] tr);
    hsel = 1'b1; haddr = a; hwrite = w; hsize = sz; htrans = tr;
  endtask

  task automatic idle_bus;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010;
  endtask

  task automatic push(input logic r, input logic c, input logic [31:0] d);
    exp_t e;
    e.resp = r; e.chk = c; e.data = d;
    sb.push_back(e);
  endtask

  task automatic chk_sig(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({hready_o, hresp, bus_en, bus_we} !== 4'b1000 || hrdata !== 32'h0 || bus_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset: hready=%0b hresp=%0b en=%0b we=%0b hrdata=%h addr=%h, want 1 0 0 0 0 0",
               hready_o, hresp, bus_en, bus_we, hrdata, bus_addr);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_write;
    ack_lat = 2;
    addr_phase(32'h10, 1'b1, 3'b010, 2'b10);
    push(1'b0, 1'b0, 32'h0);
    cyc;
    idle_bus;
    hwdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus_en !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h10 ||
          bus_data_in !== 32'hDEADBEEF || hready_o !== (i == 2)) begin
        errors++;
        $display("FAIL wr_access[%0d]: en=%0b we=%0b addr=%h din=%h hready=%0b, want 1 1 10 deadbeef %0b",
                 i, bus_en, bus_we, bus_addr, bus_data_in, hready_o, (i == 2));
      end
      cyc;
    end
    @(negedge clk);
    checks++;
    if (bus_en !== 1'b0 || hready_o !== 1'b1 || last_wdata !== 32'hDEADBEEF || last_waddr !== 32'h10) begin
      errors++;
      $display("FAIL wr_done: en=%0b hready=%0b wdata=%h waddr=%h, want 0 1 deadbeef 10",
               bus_en, hready_o, last_wdata, last_waddr);
    end
    cyc;
  endtask

  task automatic test_back_to_back;
    ack_lat = 0;
    addr_phase(32'h0, 1'b0, 3'b010, 2'b10);
    push(1'b0, 1'b1, 32'h11);
    cyc;
    addr_phase(32'h4, 1'b0, 3'b010, 2'b11);
    push(1'b0, 1'b1, 32'h22);
    @(negedge clk);
    chk_sig("b2b_first", {bus_en, hready_o, bus_addr[29:0]}, {1'b1, 1'b1, 30'h0});
    chk_sig("b2b_rdata1", hrdata, 32'h11);
    cyc;
    idle_bus;
    @(negedge clk);
    chk_sig("b2b_second", {bus_en, hready_o, bus_addr[29:0]}, {1'b1, 1'b1, 30'h4});
    chk_sig("b2b_rdata2", hrdata, 32'h22);
    cyc;
    @(negedge clk);
    chk_sig("b2b_idle_hold", {bus_en, hready_o, hrdata[29:0]}, {1'b0, 1'b1, 30'h22});
    cyc;
  endtask

  // Two-cycle ERROR tail shared by the illegal, error and timeout scenarios.
  task automatic err_tail(input string name);
    @(negedge clk);
    chk_sig({name, "_err1"}, {29'h0, bus_en, hready_o, hresp}, {29'h0, 3'b001});
    cyc;
    @(negedge clk);
    chk_sig({name, "_err2"}, {29'h0, bus_en, hready_o, hresp}, {29'h0, 3'b011});
    cyc;
    @(negedge clk);
    chk_sig({name, "_idle"}, {29'h0, bus_en, hready_o, hresp}, {29'h0, 3'b010});
  endtask

  task automatic test_illegal(input string name, input logic [31:0] a, input logic [2:0] sz);
    ack_lat = 0;
    addr_phase(a, 1'b0, sz, 2'b10);
    push(1'b1, 1'b0, 32'h0);
    cyc;
    idle_bus;
    err_tail(name);
    cyc;
  endtask

  task automatic test_bus_err;
    ack_lat = 0;
    err_mode = 1'b1;
    addr_phase(32'h8, 1'b1, 3'b010, 2'b10);
    push(1'b1, 1'b0, 32'h0);
    cyc;
    idle_bus;
    hwdata = 32'h12345678;
    @(negedge clk);
    chk_sig("berr_access", {29'h0, bus_en, hready_o, hresp}, {29'h0, 3'b100});
    cyc;
    err_mode = 1'b0;
    err_tail("berr");
    chk_sig("berr_nowrite", last_wdata, 32'hDEADBEEF);
    cyc;
  endtask

  task automatic test_timeout;
    int en_cycles;
    ack_lat = -1;
    en_cycles = 0;
    addr_phase(32'hC, 1'b0, 3'b010, 2'b10);
    push(1'b1, 1'b0, 32'h0);
    cyc;
    idle_bus;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_en === 1'b1 && hready_o === 1'b0) en_cycles++;
      cyc;
    end
    chk_sig("tmo_en_cycles", 32'(en_cycles), 32'd4);
    err_tail("tmo");
    cyc;
  endtask

  task automatic test_reset_mid;
    ack_lat = -1;
    addr_phase(32'h8, 1'b0, 3'b010, 2'b10);
    push(1'b1, 1'b0, 32'h0);
    cyc;
    idle_bus;
    #2;
    chk_sig("rmid_before", {31'h0, bus_en}, 32'h1);
    rst = 1'b1;
    #1;
    chk_sig("rmid_async", {29'h0, bus_en, hready_o, hresp}, {29'h0, 3'b010});
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ack_lat = 1;
    addr_phase(32'h8, 1'b0, 3'b010, 2'b10);
    push(1'b0, 1'b1, 32'hCAFE0008);
    cyc;
    idle_bus;
    @(negedge clk);
    chk_sig("rmid_wait", {30'h0, bus_en, hready_o}, {30'h0, 2'b10});
    cyc;
    @(negedge clk);
    chk_sig("rmid_done", {30'h0, bus_en, hready_o}, {30'h0, 2'b11});
    chk_sig("rmid_rdata", hrdata, 32'hCAFE0008);
    cyc;
    @(negedge clk);
    chk_sig("rmid_idle", {31'h0, bus_en}, 32'h0);
    cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rmem[i] = 32'hA500_0000 | 32'(i);
    rmem[0] = 32'h11;
    rmem[1] = 32'h22;
    rmem[2] = 32'hCAFE0008;
    test_reset;
    test_single_write;
    test_back_to_back;
    test_illegal("size", 32'h4, 3'b000);
    test_illegal("align", 32'h2, 3'b010);
    test_bus_err;
    test_timeout;
    test_reset_mid;
    repeat (2) cyc;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
